// File: rtl/shift_left_pkg.sv
// shift_left_pkg: shared lane-shifter constants and scheduler state encoding
package shift_left_pkg;
   localparam int LANES    = 8;
   localparam int LANE_W   = 12;
   localparam int DATA_W   = LANES * LANE_W;
   localparam int MAX_PASS = 5;
   typedef enum logic [1:0] {IDLE, SHIFT, RESP} sched_state_t;
endpackage

// File: rtl/shift_left_sched_if.sv
// shift_left_sched_if: two-requester request port plus tagged response port
interface shift_left_sched_if;
   import shift_left_pkg::*;
   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [2*DATA_W-1:0] req_data;
   logic [5:0]          req_shift;
   logic [2*LANE_W-1:0] req_fill;
   logic                resp_valid;
   logic                resp_ready;
   logic [DATA_W-1:0]   resp_data;
   logic                resp_id;
   logic                busy;
   modport master (
      output req_valid, req_data, req_shift, req_fill, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_id, busy
   );
   modport slave (
      input  req_valid, req_data, req_shift, req_fill, resp_ready,
      output req_ready, resp_valid, resp_data, resp_id, busy
   );
endinterface

// File: rtl/shift_left.sv
// shift_left: combinational lane shifter, 0..MAX_PASS lanes, vacated lanes take fill
module shift_left #(
   parameter int LANES    = 8,
   parameter int LANE_W   = 12,
   parameter int MAX_PASS = 5
) (
   input  logic [LANES*LANE_W-1:0] in,
   input  logic [2:0]              shift,
   input  logic [LANE_W-1:0]       fill,
   output logic [LANES*LANE_W-1:0] out,
   output logic                    out_valid
);
   localparam int DW = LANES * LANE_W;
   assign out       = (in << (shift * LANE_W)) | ({LANES{fill}} & ~({DW{1'b1}} << (shift * LANE_W)));
   assign out_valid = int'(shift) <= MAX_PASS;
endmodule

// File: rtl/shift_left_sched.sv
// shift_left_sched: round-robin two-requester scheduler that runs 0-7 lane shifts
// as one or two registered passes through a single shift_left.
module shift_left_sched
   import shift_left_pkg::*;
#(
   parameter int LANES    = shift_left_pkg::LANES,
   parameter int LANE_W   = shift_left_pkg::LANE_W,
   parameter int MAX_PASS = shift_left_pkg::MAX_PASS
) (
   input logic               clk,
   input logic               rst,
   shift_left_sched_if.slave bus
);
   localparam int DW = LANES * LANE_W;
   sched_state_t      state, state_n;
   logic [DW-1:0]     data, sh_out;
   logic [2:0]        rem, amt;
   logic [LANE_W-1:0] fill;
   logic              id, prio, g, accept, sh_valid;
   // a lone requester wins outright; prio only breaks ties
   assign g      = &bus.req_valid ? prio : bus.req_valid[1];
   assign accept = state == IDLE && |bus.req_valid && !rst;
   assign amt    = rem > 3'(MAX_PASS) ? 3'(MAX_PASS) : rem;
   shift_left #(.LANES(LANES), .LANE_W(LANE_W), .MAX_PASS(MAX_PASS)) u_shift (
      .in(data), .shift(amt), .fill(fill), .out(sh_out), .out_valid(sh_valid)
   );
   always_comb begin
      state_n        = state;
      bus.req_ready  = accept ? (g ? 2'b10 : 2'b01) : 2'b00;
      bus.resp_valid = state == RESP;
      bus.resp_data  = data;
      bus.resp_id    = id;
      bus.busy       = state != IDLE;
      case (state)
         IDLE:    state_n = accept ? SHIFT : IDLE;
         SHIFT:   state_n = rem == amt ? RESP : SHIFT;
         RESP:    state_n = bus.resp_ready ? IDLE : RESP;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         data  <= '0;
         rem   <= '0;
         fill  <= '0;
         id    <= 1'b0;
         prio  <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) begin
            data <= g ? bus.req_data[2*DW-1:DW] : bus.req_data[DW-1:0];
            rem  <= g ? bus.req_shift[5:3] : bus.req_shift[2:0];
            fill <= g ? bus.req_fill[2*LANE_W-1:LANE_W] : bus.req_fill[LANE_W-1:0];
            id   <= g;
            prio <= ~g;
         end
         // a zero shift still makes one pass, leaving data unchanged
         if (state == SHIFT) begin
            data <= sh_out;
            rem  <= rem - amt;
            assert (sh_valid);
         end
      end
   end
endmodule

// File: tb/tb_shift_left_sched.sv
// tb_shift_left_sched: directed scenario tasks with hand-computed results
module tb_shift_left_sched;
   logic clk = 1'b0;
   logic rst;
   int checks = 0;
   int errors = 0;
   localparam logic [95:0] D0 = 96'h111_222_333_444_555_666_777_888;
   localparam logic [95:0] D1 = 96'hABC_DEF_012_345_678_9AB_CDE_F01;
   shift_left_sched_if bus ();
   shift_left_sched dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      rst = 1'b1;
      bus.req_valid = 2'b11;
      bus.req_data = '0;
      bus.req_shift = '0;
      bus.req_fill = '0;
      bus.resp_ready = 1'b0;
      step();
      step();
      checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", bus.req_ready); end
      bus.req_valid = 2'b00;
      #1;
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", bus.resp_valid); end
      checks++; if (bus.resp_data !== 96'h0) begin errors++; $display("FAIL reset_resp_data got %h exp 0", bus.resp_data); end
      checks++; if (bus.resp_id !== 1'b0) begin errors++; $display("FAIL reset_resp_id got %b exp 0", bus.resp_id); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      rst = 1'b0;
      step();
   endtask
   task automatic test_single();
      bus.req_data = {96'h0, 96'h0123_4567_89AB_CDEF_0011_2233};
      bus.req_shift = {3'd0, 3'd1};
      bus.req_fill = {12'h000, 12'hFFF};
      bus.req_valid = 2'b01;
      #1;
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL single_grant got %b exp 01", bus.req_ready); end
      step();
      bus.req_valid = 2'b00;
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b exp 0", bus.resp_valid); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", bus.busy); end
      step();
      checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", bus.resp_valid); end
      checks++; if (bus.resp_data !== 96'h345_678_9AB_CDE_F00_112_233_FFF) begin errors++; $display("FAIL single_data got %h exp 3456789abcdef00112233fff", bus.resp_data); end
      checks++; if (bus.resp_id !== 1'b0) begin errors++; $display("FAIL single_id got %b exp 0", bus.resp_id); end
      bus.resp_ready = 1'b1;
      step();
      bus.resp_ready = 1'b0;
      checks++; if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL single_done got valid %b busy %b exp 0 0", bus.resp_valid, bus.busy); end
   endtask
   task automatic test_two_pass();
      bus.req_data = {{96{1'b1}}, 96'h0};
      bus.req_shift = {3'd7, 3'd0};
      bus.req_fill = {12'hA5A, 12'h000};
      bus.req_valid = 2'b10;
      #1;
      checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL two_pass_grant got %b exp 10", bus.req_ready); end
      step();
      bus.req_valid = 2'b00;
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL two_pass_t1 got %b exp 0", bus.resp_valid); end
      step();
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL two_pass_t2 got %b exp 0", bus.resp_valid); end
      step();
      checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL two_pass_t3 got %b exp 1", bus.resp_valid); end
      checks++; if (bus.resp_data !== {12'hFFF, {7{12'hA5A}}}) begin errors++; $display("FAIL two_pass_data got %h exp fffa5a...a5a", bus.resp_data); end
      checks++; if (bus.resp_id !== 1'b1) begin errors++; $display("FAIL two_pass_id got %b exp 1", bus.resp_id); end
      bus.resp_ready = 1'b1;
      step();
      bus.resp_ready = 1'b0;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL two_pass_done got busy %b exp 0", bus.busy); end
   endtask
   task automatic test_shift0();
      bus.req_data = {96'h0, D1};
      bus.req_shift = {3'd0, 3'd0};
      bus.req_fill = {12'h000, 12'h123};
      bus.resp_ready = 1'b1;
      bus.req_valid = 2'b01;
      #1;
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL shift0_grant got %b exp 01", bus.req_ready); end
      step();
      bus.req_valid = 2'b00;
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL shift0_t1 got %b exp 0", bus.resp_valid); end
      step();
      checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL shift0_t2 got %b exp 1", bus.resp_valid); end
      checks++; if (bus.resp_data !== D1) begin errors++; $display("FAIL shift0_data got %h exp %h", bus.resp_data, D1); end
      step();
      checks++; if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL shift0_done got valid %b busy %b exp 0 0", bus.resp_valid, bus.busy); end
      bus.resp_ready = 1'b0;
   endtask
   task automatic test_contention();
      logic e;
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.req_data = {D1, D0};
      bus.req_shift = {3'd3, 3'd2};
      bus.req_fill = {12'h111, 12'h000};
      bus.resp_ready = 1'b1;
      bus.req_valid = 2'b11;
      #1;
      for (int i = 0; i < 4; i++) begin
         e = 1'(i % 2);
         checks++; if (bus.req_ready !== (e ? 2'b10 : 2'b01)) begin errors++; $display("FAIL contention_grant%0d got %b exp %b", i, bus.req_ready, e ? 2'b10 : 2'b01); end
         step();
         checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL contention_busy_ready%0d got %b exp 00", i, bus.req_ready); end
         step();
         checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== e) begin errors++; $display("FAIL contention_resp%0d got valid %b id %b exp 1 %b", i, bus.resp_valid, bus.resp_id, e); end
         checks++; if (bus.resp_data !== (e ? 96'h345_678_9AB_CDE_F01_111_111_111 : 96'h333_444_555_666_777_888_000_000)) begin errors++; $display("FAIL contention_data%0d got %h", i, bus.resp_data); end
         step();
      end
      bus.req_valid = 2'b00;
      bus.resp_ready = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL contention_end got busy %b exp 0", bus.busy); end
   endtask
   task automatic test_backpressure();
      bus.req_data = {D1, D0};
      bus.req_shift = {3'd4, 3'd2};
      bus.req_fill = {12'h000, 12'h000};
      bus.req_valid = 2'b10;
      #1;
      checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL bp_grant got %b exp 10", bus.req_ready); end
      step();
      bus.req_valid = 2'b11;
      #1;
      checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL bp_shift_ready got %b exp 00", bus.req_ready); end
      step();
      for (int i = 0; i < 10; i++) begin
         checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b1) begin errors++; $display("FAIL bp_hold%0d got valid %b id %b exp 1 1", i, bus.resp_valid, bus.resp_id); end
         checks++; if (bus.resp_data !== 96'h678_9AB_CDE_F01_000_000_000_000) begin errors++; $display("FAIL bp_data%0d got %h exp 6789abcdef01000000000000", i, bus.resp_data); end
         checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready%0d got %b exp 00", i, bus.req_ready); end
         step();
      end
      bus.req_valid = 2'b00;
      bus.resp_ready = 1'b1;
      #1;
      checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL bp_last got %b exp 1", bus.resp_valid); end
      step();
      bus.resp_ready = 1'b0;
      checks++; if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL bp_done got valid %b busy %b exp 0 0", bus.resp_valid, bus.busy); end
   endtask
   task automatic test_reset_mid();
      bus.req_data = {D1, D0};
      bus.req_shift = {3'd5, 3'd6};
      bus.req_fill = {12'hFFF, 12'h000};
      bus.req_valid = 2'b01;
      #1;
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL mid_grant got %b exp 01", bus.req_ready); end
      step();
      bus.req_valid = 2'b00;
      step();
      checks++; if (bus.busy !== 1'b1 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL mid_pass2 got busy %b valid %b exp 1 0", bus.busy, bus.resp_valid); end
      rst = 1'b1;
      step();
      checks++; if (bus.req_ready !== 2'b00 || bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl got ready %b valid %b busy %b exp 00 0 0", bus.req_ready, bus.resp_valid, bus.busy); end
      checks++; if (bus.resp_data !== 96'h0 || bus.resp_id !== 1'b0) begin errors++; $display("FAIL mid_rst_data got %h id %b exp 0 0", bus.resp_data, bus.resp_id); end
      rst = 1'b0;
      step();
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_resp got %b exp 0", bus.resp_valid); end
      bus.req_valid = 2'b10;
      #1;
      checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL mid_r1_grant got %b exp 10", bus.req_ready); end
      step();
      bus.req_valid = 2'b00;
      step();
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b1) begin errors++; $display("FAIL mid_r1_resp got valid %b id %b exp 1 1", bus.resp_valid, bus.resp_id); end
      checks++; if (bus.resp_data !== 96'h9AB_CDE_F01_FFF_FFF_FFF_FFF_FFF) begin errors++; $display("FAIL mid_r1_data got %h exp 9abcdef01fffffffffffffff", bus.resp_data); end
      bus.resp_ready = 1'b1;
      step();
      bus.resp_ready = 1'b0;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_r1_done got busy %b exp 0", bus.busy); end
   endtask
   initial begin
      test_reset();
      test_single();
      test_two_pass();
      test_shift0();
      test_contention();
      test_backpressure();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
